// File: rtl/dpsk_deserializer_if.sv
// Port bundle for dpsk_deserializer: serial DPSK line in, framed parallel words out.
// parity_err exists only when DPSK_PARITY_EN is defined.
interface dpsk_deserializer_if #(
  parameter int WORD_W = 10,
  parameter int ERR_W  = 8
);
  logic              rx_bit;
  logic              rx_start;
  logic [WORD_W-1:0] word;
  logic              word_valid;
  logic              frame_err;
  logic [ERR_W-1:0]  err_count;
  logic              busy;
`ifdef DPSK_PARITY_EN
  logic              parity_err;

  modport master (
    output rx_bit, rx_start,
    input  word, word_valid, frame_err, err_count, busy, parity_err
  );

  modport slave (
    input  rx_bit, rx_start,
    output word, word_valid, frame_err, err_count, busy, parity_err
  );
`else
  modport master (
    output rx_bit, rx_start,
    input  word, word_valid, frame_err, err_count, busy
  );

  modport slave (
    input  rx_bit, rx_start,
    output word, word_valid, frame_err, err_count, busy
  );
`endif
endinterface

// File: rtl/dpsk_deserializer.sv
// Differential DPSK decoder and word framer with a saturating framing-error counter.
// Define DPSK_PARITY_EN to append an even-parity bit to every frame and report parity_err.
module dpsk_deserializer #(
  parameter int WORD_W = 10,
  parameter int ERR_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  dpsk_deserializer_if.slave bus
);

`ifdef DPSK_PARITY_EN
  localparam int FRAME_W = WORD_W + 1;
`else
  localparam int FRAME_W = WORD_W;
`endif
  localparam int               CNT_W    = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(FRAME_W - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  function automatic logic even_parity(input logic [WORD_W-1:0] v);
    return ^v;
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    if (v == ERR_MAX) begin
      return v;
    end else begin
      return v + ERR_W'(1);
    end
  endfunction

  state_t            state_r, state_nxt_s;
  logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
  logic [WORD_W-1:0] shreg_r, shreg_nxt_s;
  logic              prev_r;
  logic              d_s;
  logic [WORD_W-1:0] word_r, word_nxt_s;
  logic              word_valid_r, word_valid_nxt_s;
  logic              frame_err_r, frame_err_nxt_s;
  logic [ERR_W-1:0]  err_count_r, err_count_nxt_s;
  logic              busy_r;
`ifdef DPSK_PARITY_EN
  logic              parity_err_r, parity_err_nxt_s;
`endif

  assign d_s = bus.rx_bit ^ prev_r;

  // FSM state, bit position, partial word and the differential reference bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      shreg_r <= '0;
      prev_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      shreg_r <= shreg_nxt_s;
      prev_r  <= bus.rx_bit;
    end
  end

  // Next-state, shift and output decisions for the sampled symbol
  always_comb begin
    state_nxt_s      = state_r;
    cnt_nxt_s        = cnt_r;
    shreg_nxt_s      = shreg_r;
    word_nxt_s       = word_r;
    word_valid_nxt_s = 1'b0;
    frame_err_nxt_s  = 1'b0;
    err_count_nxt_s  = err_count_r;
`ifdef DPSK_PARITY_EN
    parity_err_nxt_s = parity_err_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (bus.rx_start) begin
          shreg_nxt_s[0] = d_s;
          cnt_nxt_s      = CNT_W'(1);
          state_nxt_s    = ST_SHIFT;
        end else begin
          state_nxt_s    = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (bus.rx_start) begin
          // A start inside a frame abandons the partial word and restarts on this bit
          shreg_nxt_s[0]  = d_s;
          cnt_nxt_s       = CNT_W'(1);
          frame_err_nxt_s = 1'b1;
          err_count_nxt_s = sat_inc(err_count_r);
        end else if (cnt_r == LAST_POS) begin
`ifdef DPSK_PARITY_EN
          word_nxt_s       = shreg_r;
          parity_err_nxt_s = even_parity(shreg_r) ^ d_s;
`else
          word_nxt_s       = {d_s, shreg_r[WORD_W-2:0]};
`endif
          word_valid_nxt_s = 1'b1;
          cnt_nxt_s        = '0;
          state_nxt_s      = ST_IDLE;
        end else begin
          for (int i = 0; i < WORD_W; i++) begin
            shreg_nxt_s[i] = (cnt_r == CNT_W'(i)) ? d_s : shreg_r[i];
          end
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = '0;
      end
    endcase
  end

  // Registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_r       <= '0;
      word_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
      err_count_r  <= '0;
      busy_r       <= 1'b0;
`ifdef DPSK_PARITY_EN
      parity_err_r <= 1'b0;
`endif
    end else begin
      word_r       <= word_nxt_s;
      word_valid_r <= word_valid_nxt_s;
      frame_err_r  <= frame_err_nxt_s;
      err_count_r  <= err_count_nxt_s;
      busy_r       <= (state_nxt_s == ST_SHIFT);
`ifdef DPSK_PARITY_EN
      parity_err_r <= parity_err_nxt_s;
`endif
    end
  end

  assign bus.word       = word_r;
  assign bus.word_valid = word_valid_r;
  assign bus.frame_err  = frame_err_r;
  assign bus.err_count  = err_count_r;
  assign bus.busy       = busy_r;
`ifdef DPSK_PARITY_EN
  assign bus.parity_err = parity_err_r;
`endif

endmodule

// File: tb/tb_dpsk_deserializer.sv
// Scoreboard bench for dpsk_deserializer: DPSK-encodes words onto the line and checks
// framed output, timing, framing errors, counter saturation and asynchronous reset.
module tb_dpsk_deserializer;
  localparam int WORD_W = 10;
  localparam int ERR_W  = 8;
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  typedef struct {
    logic [WORD_W-1:0] data;
    logic              perr;
    int                due;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  dpsk_deserializer_if #(.WORD_W(WORD_W), .ERR_W(ERR_W)) bus ();

  dpsk_deserializer #(.WORD_W(WORD_W), .ERR_W(ERR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int                edge_cnt  = 0;
  int                n_checks  = 0;
  int                n_fail    = 0;
  exp_t              sb[$];
  bit                exp_ferr[int];
  logic [WORD_W-1:0] last_word = '0;
  logic [ERR_W-1:0]  exp_err   = '0;
  logic              line_prev = 1'b0;
  bit                partial   = 1'b0;
`ifdef DPSK_PARITY_EN
  logic              par_flip  = 1'b0;
`endif

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Output monitor: every cycle, compare against what the scoreboard says is due
  always @(negedge clk) begin
    bit due_now;
    due_now = (sb.size() > 0) && (sb[0].due == edge_cnt);
    check_eq("word_valid", {31'd0, bus.word_valid}, {31'd0, due_now});
    if (due_now) begin
      last_word = sb[0].data;
`ifdef DPSK_PARITY_EN
      check_eq("parity_err", {31'd0, bus.parity_err}, {31'd0, sb[0].perr});
`endif
      void'(sb.pop_front());
    end
    check_eq("word", 32'(bus.word), 32'(last_word));
    check_eq("frame_err", {31'd0, bus.frame_err}, {31'd0, exp_ferr.exists(edge_cnt)});
  end

  // One symbol: DPSK-encode decoded bit d onto the line
  task automatic drive_bit(input logic d, input logic st);
    @(negedge clk);
    line_prev    = line_prev ^ d;
    bus.rx_bit   = line_prev;
    bus.rx_start = st;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_bit(1'b0, 1'b0);
  endtask

  task automatic start_bit(input logic d);
    drive_bit(d, 1'b1);
    if (partial) begin
      exp_ferr[edge_cnt + 1] = 1'b1;
      if (exp_err != ERR_MAX) exp_err = exp_err + 8'd1;
    end
    partial = 1'b1;
  endtask

  task automatic send_partial(input logic [WORD_W-1:0] data, input int nbits);
    start_bit(data[0]);
    for (int i = 1; i < nbits; i++) drive_bit(data[i], 1'b0);
  endtask

  task automatic send_frame(input logic [WORD_W-1:0] data);
    exp_t e;
    send_partial(data, WORD_W);
`ifdef DPSK_PARITY_EN
    drive_bit((^data) ^ par_flip, 1'b0);
    e.perr = par_flip;
`else
    e.perr = 1'b0;
`endif
    e.data  = data;
    e.due   = edge_cnt + 1;
    sb.push_back(e);
    partial = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    bus.rx_bit   = 1'b0;
    bus.rx_start = 1'b0;
    #1;
    check_eq("rst_word", 32'(bus.word), 32'd0);
    check_eq("rst_word_valid", {31'd0, bus.word_valid}, 32'd0);
    check_eq("rst_frame_err", {31'd0, bus.frame_err}, 32'd0);
    check_eq("rst_err_count", 32'(bus.err_count), 32'd0);
    check_eq("rst_busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    // Single word: line bits 1,1,0,0,0,1,1,0,0,1 decode to 10'h2A5
    send_frame(10'h2A5);
    check_eq("busy_mid", {31'd0, bus.busy}, 32'd1);
    idle(1);
    check_eq("busy_done", {31'd0, bus.busy}, 32'd0);
    check_eq("err_after_single", 32'(bus.err_count), 32'd0);
    idle(2);

    // Back-to-back words, no gap
    send_frame(10'h155);
    send_frame(10'h0F3);
    send_frame(10'h3FF);
    idle(3);

    // Framing error: restart at bit 4
    send_partial(10'h1C7, 4);
    send_frame(10'h06B);
    idle(2);
    check_eq("err_after_abort", 32'(bus.err_count), 32'(exp_err));

    // Random words with occasional aborts, including a restart right after a start
    for (int k = 0; k < 8; k++) begin
      if ($urandom_range(0, 2) == 0) send_partial(WORD_W'($urandom), $urandom_range(1, WORD_W - 1));
      send_frame(WORD_W'($urandom));
      idle($urandom_range(0, 2));
    end
    idle(2);
    check_eq("err_random", 32'(bus.err_count), 32'(exp_err));

    // Saturation: 300 aborted words
    for (int k = 0; k < 300; k++) send_partial(WORD_W'($urandom), 2);
    send_frame(10'h2C3);
    idle(2);
    check_eq("err_saturated", 32'(bus.err_count), 32'(exp_err));
    check_eq("err_is_max", 32'(bus.err_count), 32'd255);

    // Asynchronous reset during bit 6 of a word
    send_partial(10'h3A1, 6);
    drive_bit(1'b1, 1'b0);
    @(posedge clk);
    #2;
    rst          = 1'b1;
    bus.rx_bit   = 1'b0;
    bus.rx_start = 1'b0;
    line_prev    = 1'b0;
    partial      = 1'b0;
    last_word    = '0;
    exp_err      = '0;
    #1;
    check_eq("arst_word", 32'(bus.word), 32'd0);
    check_eq("arst_word_valid", {31'd0, bus.word_valid}, 32'd0);
    check_eq("arst_frame_err", {31'd0, bus.frame_err}, 32'd0);
    check_eq("arst_err_count", 32'(bus.err_count), 32'd0);
    check_eq("arst_busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    send_frame(10'h2A5);
    idle(2);
    check_eq("err_after_reset", 32'(bus.err_count), 32'd0);

`ifdef DPSK_PARITY_EN
    // Good parity, then the same word with a flipped parity bit
    par_flip = 1'b0;
    send_frame(10'h2A5);
    par_flip = 1'b1;
    send_frame(10'h2A5);
    par_flip = 1'b0;
    idle(2);
`endif

    idle(3);
    check_eq("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
